// File: rtl/bot_update_hsk.sv
// N-channel bot update handshake: per-channel pending flag, coherent info snapshot,
// saturating overrun counter and a registered lowest-index interrupt request.
module bot_update_hsk #(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 32,
    parameter int OVF_W       = 8,
    parameter int EDGE_MODE   = 1,
    parameter int SNAP_POLICY = 0,
    localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     SI_ClkIn,
    input  logic                     SI_Reset_N,
    input  logic [N_CH-1:0]          upd_in,
    input  logic [N_CH*DATA_W-1:0]   info_in,
    input  logic [N_CH-1:0]          ack_in,
    input  logic [N_CH-1:0]          int_mask,
    input  logic [N_CH-1:0]          ovr_clr,
    output logic [N_CH-1:0]          pending,
    output logic [N_CH*DATA_W-1:0]   snap_out,
    output logic [N_CH*OVF_W-1:0]    ovr_cnt,
    output logic                     irq,
    output logic [IDX_W-1:0]         irq_ch
);

    logic [N_CH-1:0]  upd_q;
    logic [N_CH-1:0]  evt;
    logic [N_CH-1:0]  active;
    logic             irq_next;
    logic [IDX_W-1:0] irq_ch_next;

    // upd_q resets to all ones so a strobe already high at reset release is not an event.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            upd_q <= '1;
        end else begin
            upd_q <= upd_in;
        end
    end

    assign evt = upd_in & ((EDGE_MODE != 0) ? ~upd_q : {N_CH{1'b1}});

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic              pend_r;
        logic [DATA_W-1:0] snap_r;
        logic [OVF_W-1:0]  cnt_r;
        logic              ovr_inc;
        logic              take_snap;

        assign ovr_inc   = evt[g] & ~ack_in[g] & pend_r;
        // A new event beats a same-cycle ack; only a true overrun may keep the old snapshot.
        assign take_snap = evt[g] & (ack_in[g] | ~pend_r | (SNAP_POLICY != 0));

        always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
            if (!SI_Reset_N) begin
                pend_r <= 1'b0;
                snap_r <= '0;
                cnt_r  <= '0;
            end else begin
                if (evt[g]) begin
                    pend_r <= 1'b1;
                end else if (ack_in[g]) begin
                    pend_r <= 1'b0;
                end

                if (take_snap) begin
                    snap_r <= info_in[g*DATA_W +: DATA_W];
                end

                if (ovr_clr[g]) begin
                    cnt_r <= ovr_inc ? OVF_W'(1) : '0;
                end else if (ovr_inc && (cnt_r != {OVF_W{1'b1}})) begin
                    cnt_r <= cnt_r + OVF_W'(1);
                end
            end
        end

        assign pending[g]                     = pend_r;
        assign snap_out[g*DATA_W +: DATA_W]   = snap_r;
        assign ovr_cnt[g*OVF_W +: OVF_W]      = cnt_r;
    end

    assign active = pending & int_mask;

    // Scanning downward leaves the lowest-index active channel as the final winner.
    always_comb begin
        irq_next    = |active;
        irq_ch_next = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_ch_next = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            irq    <= 1'b0;
            irq_ch <= '0;
        end else begin
            irq    <= irq_next;
            irq_ch <= irq_ch_next;
        end
    end

endmodule

// File: tb/tb_bot_update_hsk.sv
// Scoreboard bench for bot_update_hsk: stimulus pushes hand-computed expectations,
// a separate monitor pops and compares them on the cycle they fall due.
module tb_bot_update_hsk;

   localparam int N_CH   = 4;
   localparam int DATA_W = 32;
   localparam int OVF_W  = 2;

   logic                   SI_ClkIn = 1'b0;
   logic                   SI_Reset_N;
   logic [N_CH-1:0]        upd_in;
   logic [N_CH*DATA_W-1:0] info_in;
   logic [N_CH-1:0]        ack_in;
   logic [N_CH-1:0]        int_mask;
   logic [N_CH-1:0]        ovr_clr;
   logic [N_CH-1:0]        pending;
   logic [N_CH*DATA_W-1:0] snap_out;
   logic [N_CH*OVF_W-1:0]  ovr_cnt;
   logic                   irq;
   logic [1:0]             irq_ch;

   bot_update_hsk #(
      .N_CH(N_CH), .DATA_W(DATA_W), .OVF_W(OVF_W), .EDGE_MODE(1), .SNAP_POLICY(0)
   ) dut (
      .SI_ClkIn(SI_ClkIn), .SI_Reset_N(SI_Reset_N), .upd_in(upd_in), .info_in(info_in),
      .ack_in(ack_in), .int_mask(int_mask), .ovr_clr(ovr_clr), .pending(pending),
      .snap_out(snap_out), .ovr_cnt(ovr_cnt), .irq(irq), .irq_ch(irq_ch)
   );

   always #5 SI_ClkIn = ~SI_ClkIn;

   int cyc = 0;
   always @(posedge SI_ClkIn) cyc <= cyc + 1;

   typedef enum {K_PEND, K_SNAP, K_OVR, K_IRQ, K_IRQCH} kind_e;
   typedef struct {
      string       name;
      kind_e       kind;
      int          ch;
      logic [31:0] expv;
      int          due;
   } exp_t;

   exp_t sb[$];
   int compared   = 0;
   int mismatched = 0;

   task automatic applyStimulus(input logic [3:0] upd, input logic [3:0] ack, input logic [3:0] clr);
      upd_in  = upd;
      ack_in  = ack;
      ovr_clr = clr;
      @(negedge SI_ClkIn);
   endtask

   task automatic setInfo(input int ch, input logic [31:0] v);
      info_in[ch*DATA_W +: DATA_W] = v;
   endtask

   function automatic logic [31:0] actualOf(input exp_t e);
      case (e.kind)
         K_PEND:  return {28'b0, pending};
         K_SNAP:  return snap_out[e.ch*DATA_W +: DATA_W];
         K_OVR:   return {30'b0, ovr_cnt[e.ch*OVF_W +: OVF_W]};
         K_IRQ:   return {31'b0, irq};
         default: return {30'b0, irq_ch};
      endcase
   endfunction

   task automatic checkOutput(input string name, input kind_e k, input int ch,
                              input logic [31:0] expv, input int lat);
      exp_t e;
      logic [31:0] act;
      e.name = name;
      e.kind = k;
      e.ch   = ch;
      e.expv = expv;
      e.due  = cyc + lat;
      if (lat == 0) begin
         act = actualOf(e);
         compared++;
         if (act !== e.expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)",
                     e.name, act, e.expv, cyc);
         end
      end else begin
         sb.push_back(e);
      end
   endtask

   // Monitor: compares every expectation whose due cycle has arrived, just after the falling edge.
   initial begin
      forever begin
         @(negedge SI_ClkIn);
         #1;
         for (int i = 0; i < sb.size(); ) begin
            if (sb[i].due <= cyc) begin
               logic [31:0] act;
               act = actualOf(sb[i]);
               compared++;
               if (act !== sb[i].expv) begin
                  mismatched++;
                  $display("[TB] FAIL %s: got %h expected %h (cycle %0d)",
                           sb[i].name, act, sb[i].expv, cyc);
               end
               sb.delete(i);
            end else begin
               i++;
            end
         end
      end
   end

   // Watchdog: abort if the stimulus never reaches its end.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence following the specification's test list.
   initial begin
      upd_in     = 4'b0001;
      ack_in     = '0;
      ovr_clr    = '0;
      int_mask   = 4'b1111;
      info_in    = '0;
      SI_Reset_N = 1'b0;
      repeat (3) @(negedge SI_ClkIn);
      SI_Reset_N = 1'b1;

      // Strobe held high through reset release must not register as an event.
      applyStimulus(4'b0001, 4'b0000, 4'b0000);
      checkOutput("t1_pending_after_release", K_PEND, 0, 32'h0, 0);
      checkOutput("t1_snap0_reset", K_SNAP, 0, 32'h0, 0);
      checkOutput("t1_ovr0_reset", K_OVR, 0, 32'h0, 0);
      checkOutput("t1_irq_reset", K_IRQ, 0, 32'h0, 0);
      checkOutput("t1_irqch_reset", K_IRQCH, 0, 32'h0, 0);
      checkOutput("t1_irq_still_low", K_IRQ, 0, 32'h0, 1);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      setInfo(0, 32'hA5A5_0001);
      applyStimulus(4'b0001, 4'b0000, 4'b0000);
      checkOutput("t1_raise_pending", K_PEND, 0, 32'h1, 0);
      applyStimulus(4'b0000, 4'b0001, 4'b0000);
      checkOutput("t1_ack_clears", K_PEND, 0, 32'h0, 0);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t1_irq_settled_low", K_IRQ, 0, 32'h0, 0);

      // Single update, latency of pending vs irq, snapshot coherence, ack.
      setInfo(0, 32'h1234_5678);
      applyStimulus(4'b0001, 4'b0000, 4'b0000);
      checkOutput("t2_pending_set", K_PEND, 0, 32'h1, 0);
      checkOutput("t2_snap0", K_SNAP, 0, 32'h1234_5678, 0);
      checkOutput("t2_irq_lags", K_IRQ, 0, 32'h0, 0);
      checkOutput("t2_irq_set", K_IRQ, 0, 32'h1, 1);
      checkOutput("t2_irqch0", K_IRQCH, 0, 32'h0, 1);
      setInfo(0, 32'hFFFF_0000);
      repeat (4) applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t2_snap0_held", K_SNAP, 0, 32'h1234_5678, 0);
      applyStimulus(4'b0000, 4'b0001, 4'b0000);
      checkOutput("t2_ack_pending_clr", K_PEND, 0, 32'h0, 0);
      checkOutput("t2_irq_one_more", K_IRQ, 0, 32'h1, 0);
      checkOutput("t2_irq_clr", K_IRQ, 0, 32'h0, 1);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);

      // Three events on ch1 without ack: two overruns, oldest snapshot kept.
      setInfo(1, 32'hAAAA_0001);
      applyStimulus(4'b0010, 4'b0000, 4'b0000);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      setInfo(1, 32'hBBBB_0002);
      applyStimulus(4'b0010, 4'b0000, 4'b0000);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      setInfo(1, 32'hCCCC_0003);
      applyStimulus(4'b0010, 4'b0000, 4'b0000);
      checkOutput("t3_ovr1_two", K_OVR, 1, 32'h2, 0);
      checkOutput("t3_snap1_oldest", K_SNAP, 1, 32'hAAAA_0001, 0);
      checkOutput("t3_pending_ch1", K_PEND, 0, 32'h2, 0);
      applyStimulus(4'b0000, 4'b0010, 4'b0000);
      checkOutput("t3_ack_ch1", K_PEND, 0, 32'h0, 0);
      checkOutput("t3_ovr1_kept", K_OVR, 1, 32'h2, 0);

      // Ack and new event on ch0 in the same cycle: event wins, no overrun.
      setInfo(0, 32'h0BAD_F00D);
      applyStimulus(4'b0001, 4'b0000, 4'b0000);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t4_snap0_first", K_SNAP, 0, 32'h0BAD_F00D, 0);
      setInfo(0, 32'hDEAD_BEEF);
      applyStimulus(4'b0001, 4'b0001, 4'b0000);
      checkOutput("t4_pending_stays", K_PEND, 0, 32'h1, 0);
      checkOutput("t4_snap0_new", K_SNAP, 0, 32'hDEAD_BEEF, 0);
      checkOutput("t4_ovr0_none", K_OVR, 0, 32'h0, 0);
      applyStimulus(4'b0000, 4'b0001, 4'b0000);
      checkOutput("t4_ack_clears", K_PEND, 0, 32'h0, 0);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);

      // Simultaneous events on ch2/ch3 and the effect of int_mask on irq/irq_ch.
      int_mask = 4'b1000;
      setInfo(2, 32'h2222_2222);
      setInfo(3, 32'h3333_3333);
      applyStimulus(4'b1100, 4'b0000, 4'b0000);
      checkOutput("t5_pending_both", K_PEND, 0, 32'hC, 0);
      checkOutput("t5_snap2", K_SNAP, 2, 32'h2222_2222, 0);
      checkOutput("t5_snap3", K_SNAP, 3, 32'h3333_3333, 0);
      checkOutput("t5_irq_masked_in", K_IRQ, 0, 32'h1, 1);
      checkOutput("t5_irqch3", K_IRQCH, 0, 32'h3, 1);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      int_mask = 4'b1100;
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t5_irqch2", K_IRQCH, 0, 32'h2, 0);
      int_mask = 4'b0000;
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t5_irq_all_masked", K_IRQ, 0, 32'h0, 0);
      checkOutput("t5_irqch_zero", K_IRQCH, 0, 32'h0, 0);
      checkOutput("t5_pending_kept", K_PEND, 0, 32'hC, 0);

      // Overrun saturation on ch3 with a 2-bit counter, then clear paths.
      for (int k = 1; k <= 5; k++) begin
         setInfo(3, 32'h3000_0000 + k);
         applyStimulus(4'b1000, 4'b0000, 4'b0000);
         checkOutput($sformatf("t6_ovr3_step%0d", k), K_OVR, 3, (k > 3) ? 32'h3 : k, 0);
         applyStimulus(4'b0000, 4'b0000, 4'b0000);
      end
      checkOutput("t6_snap3_oldest", K_SNAP, 3, 32'h3333_3333, 0);
      checkOutput("t6_ovr2_independent", K_OVR, 2, 32'h0, 0);
      applyStimulus(4'b1000, 4'b0000, 4'b1000);
      checkOutput("t6_clr_with_overrun", K_OVR, 3, 32'h1, 0);
      applyStimulus(4'b0000, 4'b0000, 4'b1000);
      checkOutput("t6_clr_plain", K_OVR, 3, 32'h0, 0);
      applyStimulus(4'b1000, 4'b0000, 4'b0000);
      checkOutput("t6_ovr3_again", K_OVR, 3, 32'h1, 0);

      // Reset in the middle of operation drops everything; channels work again afterwards.
      SI_Reset_N = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t7_pending_reset", K_PEND, 0, 32'h0, 0);
      checkOutput("t7_ovr3_reset", K_OVR, 3, 32'h0, 0);
      checkOutput("t7_snap3_reset", K_SNAP, 3, 32'h0, 0);
      checkOutput("t7_irq_reset", K_IRQ, 0, 32'h0, 0);
      SI_Reset_N = 1'b1;
      int_mask   = 4'b1111;
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      setInfo(1, 32'hCAFE_0001);
      applyStimulus(4'b0010, 4'b0000, 4'b0000);
      checkOutput("t7_recover_pending", K_PEND, 0, 32'h2, 0);
      checkOutput("t7_recover_irqch", K_IRQCH, 0, 32'h1, 1);
      checkOutput("t7_recover_irq", K_IRQ, 0, 32'h1, 1);

      repeat (3) applyStimulus(4'b0000, 4'b0000, 4'b0000);
      #2;
      while (sb.size() > 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s: got no sample, expected %h by cycle %0d",
                  sb[0].name, sb[0].expv, sb[0].due);
         void'(sb.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
